// File: rtl/tag_array_pkg.sv
// Shared widths, FSM state encoding and tag-entry field helpers for the tag array arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tag_array_pkg;

    localparam int SETS    = 64;
    localparam int WAYS    = 4;
    localparam int ENTRY_W = 22;
    localparam int IDX_W   = 6;
    localparam int TAG_W   = ENTRY_W - 1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // The valid flag is the top bit of a stored entry.
    function automatic logic entry_valid(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1];
    endfunction

    // The tag occupies every bit below the valid flag.
    function automatic logic [TAG_W-1:0] entry_tag(input logic [ENTRY_W-1:0] e);
        return e[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/tag_array_arbiter_if.sv
// Pipeline-side lookup, write, response and status signals of the tag array arbiter.
// Latency: n/a (wires only).
// Backpressure: lookup and write use valid/ready; the response has no ready.
interface tag_array_arbiter_if;
    import tag_array_pkg::*;

    logic               lkp_valid;
    logic               lkp_ready;
    logic [IDX_W-1:0]   lkp_set;
    logic [TAG_W-1:0]   lkp_tag;

    logic               resp_valid;
    logic [WAYS-1:0]    resp_hit;
    logic               resp_multi;

    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_set;
    logic [1:0]         wr_way;
    logic [ENTRY_W-1:0] wr_entry;

    logic               flush_req;
    logic               busy;
    logic               init_done;

    // Cache pipeline side.
    modport master (
        output lkp_valid, lkp_set, lkp_tag,
        output wr_valid, wr_set, wr_way, wr_entry,
        output flush_req,
        input  lkp_ready, wr_ready,
        input  resp_valid, resp_hit, resp_multi,
        input  busy, init_done
    );

    // Arbiter side.
    modport slave (
        input  lkp_valid, lkp_set, lkp_tag,
        input  wr_valid, wr_set, wr_way, wr_entry,
        input  flush_req,
        output lkp_ready, wr_ready,
        output resp_valid, resp_hit, resp_multi,
        output busy, init_done
    );

endinterface

// File: rtl/tag_array_hit_compare.sv
// 4-way tag compare on one SRAM read word: per-way hit vector and multi-hit flag.
// Latency: combinational.
// Backpressure: none.
module tag_array_hit_compare
    import tag_array_pkg::*;
(
    input  logic [WAYS*ENTRY_W-1:0] rdata,
    input  logic [TAG_W-1:0]        tag,
    output logic [WAYS-1:0]         hit,
    output logic                    multi
);

    // A way hits only when its entry is valid and its stored tag matches.
    always_comb begin
        hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit[w] = entry_valid(rdata[w*ENTRY_W +: ENTRY_W]) &&
                     (entry_tag(rdata[w*ENTRY_W +: ENTRY_W]) == tag);
        end
    end

    // Clearing the lowest set bit leaves something only if two or more ways hit.
    assign multi = |(hit & (hit - WAYS'(1)));

endmodule

// File: rtl/tag_array_arbiter.sv
// Owns the single-port tag SRAM: sweeps it invalid after reset/flush, arbitrates writes vs lookups.
// Latency: lookup response 1 cycle after grant; writes land at the end of the grant cycle.
// Backpressure: writes win unless a lookup has waited STARVE_LIMIT write grants; responses are never stalled.
module tag_array_arbiter #(
    parameter int SETS         = 64,
    parameter int WAYS         = 4,
    parameter int ENTRY_W      = 22,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    tag_array_arbiter_if.slave      bus,
    output logic                    sram_en,
    output logic                    sram_wmode,
    output logic [$clog2(SETS)-1:0] sram_addr,
    output logic [WAYS*ENTRY_W-1:0] sram_wdata,
    output logic [WAYS-1:0]         sram_wmask,
    input  logic [WAYS*ENTRY_W-1:0] sram_rdata
);
    import tag_array_pkg::*;

    localparam int AW = $clog2(SETS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t         state;
    logic [AW-1:0]  sweep_cnt;
    logic [SW-1:0]  starve_cnt;
    logic           init_done_q;
    logic           resp_vld_q;
    logic [TAG_W-1:0] tag_q;

    logic           in_run;
    logic           sweep;
    logic           starve;
    logic           lkp_gnt;
    logic           wr_gnt;
    logic [WAYS-1:0] hit_raw;
    logic           multi_raw;

    assign in_run = (state == RUN);
    // Qualified with reset_n so the SRAM port stays idle while reset is held.
    assign sweep  = reset_n && !in_run;
    assign starve = (starve_cnt == SW'(STARVE_LIMIT));

    // The two readies never both admit a request in the same cycle.
    assign bus.lkp_ready = in_run && (!bus.wr_valid || starve);
    assign bus.wr_ready  = in_run && !(starve && bus.lkp_valid);
    assign lkp_gnt       = bus.lkp_valid && bus.lkp_ready;
    assign wr_gnt        = bus.wr_valid && bus.wr_ready;

    assign bus.busy      = !in_run;
    assign bus.init_done = init_done_q;

    // Single RW port mux: sweep, else the granted write, else the granted lookup.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wmask = '0;
        if (sweep) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_cnt;
            sram_wmask = '1;
        end else if (wr_gnt) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = bus.wr_set;
            sram_wdata = {WAYS{bus.wr_entry}};
            sram_wmask = WAYS'(1) << bus.wr_way;
        end else if (lkp_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = bus.lkp_set;
        end
    end

    // Sweep sequencing; a flush is only accepted from RUN, so requests during a sweep are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            sweep_cnt   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                INIT, FLUSH: begin
                    sweep_cnt <= sweep_cnt + AW'(1);
                    if (sweep_cnt == AW'(SETS - 1)) begin
                        state <= RUN;
                        if (state == INIT) begin
                            init_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush_req) begin
                        state <= FLUSH;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Counts write grants that overtook a waiting lookup; cleared once the lookup is served or withdrawn.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!bus.lkp_valid || lkp_gnt) begin
            starve_cnt <= '0;
        end else if (wr_gnt) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Holds the lookup tag until the read data returns next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_vld_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            resp_vld_q <= lkp_gnt;
            if (lkp_gnt) begin
                tag_q <= bus.lkp_tag;
            end
        end
    end

    tag_array_hit_compare u_hit_compare (
        .rdata (sram_rdata),
        .tag   (tag_q),
        .hit   (hit_raw),
        .multi (multi_raw)
    );

    assign bus.resp_valid = resp_vld_q;
    assign bus.resp_hit   = resp_vld_q ? hit_raw : '0;
    assign bus.resp_multi = resp_vld_q && multi_raw;

endmodule

// File: tb/tb_tag_array_arbiter.sv
// Directed bench for tag_array_arbiter with a behavioural single-port tag SRAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_tag_array_arbiter;

    logic        clock;
    logic        reset_n;
    logic        sram_en;
    logic        sram_wmode;
    logic [5:0]  sram_addr;
    logic [87:0] sram_wdata;
    logic [3:0]  sram_wmask;
    logic [87:0] sram_rdata;
    logic [87:0] mem [64];

    int checks;
    int errors;

    tag_array_arbiter_if bus ();

    tag_array_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wmask (sram_wmask),
        .sram_rdata (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM; filled with all-ones during reset so an incomplete sweep shows up as hits.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= '1;
            sram_rdata <= '0;
        end else if (sram_en) begin
            if (sram_wmode) begin
                for (int w = 0; w < 4; w++)
                    if (sram_wmask[w]) mem[sram_addr][w*22 +: 22] <= sram_wdata[w*22 +: 22];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks sweep cycles first..last, one per negedge; call before the first of them reaches its negedge.
    task automatic sweep_check(input string name, input int first, input int last, input logic exp_done);
        for (int k = first; k <= last; k++) begin
            @(negedge clock);
            check($sformatf("%s[%0d]", name, k),
                  {sram_en, sram_wmode, sram_addr, sram_wmask, bus.busy, bus.init_done, bus.lkp_ready},
                  {1'b1, 1'b1, 6'(k), 4'hF, 1'b1, exp_done, 1'b0});
        end
    endtask

    typedef struct {
        string       name;
        logic        lv;
        logic [5:0]  ls;
        logic [20:0] lt;
        logic        wv;
        logic [5:0]  ws;
        logic [1:0]  ww;
        logic [21:0] we;
        logic        e_lr;
        logic        e_wr;
        logic        e_en;
        logic        e_wm;
        logic [5:0]  e_addr;
        logic [3:0]  e_mask;
        logic [87:0] e_wdata;
        logic        e_rv;
        logic [3:0]  e_hit;
        logic        e_multi;
    } vec_t;

    function automatic vec_t mk(string n, logic lv, logic [5:0] ls, logic [20:0] lt,
                                logic wv, logic [5:0] ws, logic [1:0] ww, logic [21:0] we,
                                logic lr, logic wr, logic en, logic wm, logic [5:0] a,
                                logic [3:0] m, logic [87:0] wd, logic rv, logic [3:0] h, logic mu);
        vec_t v;
        v.name = n; v.lv = lv; v.ls = ls; v.lt = lt; v.wv = wv; v.ws = ws; v.ww = ww; v.we = we;
        v.e_lr = lr; v.e_wr = wr; v.e_en = en; v.e_wm = wm; v.e_addr = a; v.e_mask = m;
        v.e_wdata = wd; v.e_rv = rv; v.e_hit = h; v.e_multi = mu;
        return v;
    endfunction

    task automatic drive(input logic lv, input logic [5:0] ls, input logic [20:0] lt,
                         input logic wv, input logic [5:0] ws, input logic [1:0] ww,
                         input logic [21:0] we, input logic fl);
        bus.lkp_valid = lv; bus.lkp_set = ls; bus.lkp_tag = lt;
        bus.wr_valid  = wv; bus.wr_set  = ws; bus.wr_way = ww; bus.wr_entry = we;
        bus.flush_req = fl;
    endtask

    vec_t vecs[$];

    initial begin
        logic lg;
        logic wg;
        logic exp_l;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Table: one row per cycle; responses in a row belong to the previous row's lookup.
        vecs.push_back(mk("wr5w2",    0,6'd5,21'h0,      1,6'd5,2'd2,22'h2ABCDE, 0,1,1,1,6'd5,4'b0100,{4{22'h2ABCDE}}, 0,4'h0,0));
        vecs.push_back(mk("lk5hit",   1,6'd5,21'h0ABCDE, 0,6'd0,2'd0,22'h0,      1,1,1,0,6'd5,4'b0000,88'h0,            0,4'h0,0));
        vecs.push_back(mk("lk5miss",  1,6'd5,21'h0ABCDF, 0,6'd0,2'd0,22'h0,      1,1,1,0,6'd5,4'b0000,88'h0,            1,4'b0100,0));
        vecs.push_back(mk("lk6swept", 1,6'd6,21'h1FFFFF, 0,6'd0,2'd0,22'h0,      1,1,1,0,6'd6,4'b0000,88'h0,            1,4'h0,0));
        vecs.push_back(mk("idle1",    0,6'd0,21'h0,      0,6'd0,2'd0,22'h0,      1,1,0,0,6'd0,4'b0000,88'h0,            1,4'h0,0));
        vecs.push_back(mk("wr9w0",    0,6'd0,21'h0,      1,6'd9,2'd0,22'h200123, 0,1,1,1,6'd9,4'b0001,{4{22'h200123}}, 0,4'h0,0));
        vecs.push_back(mk("wr9w3",    0,6'd0,21'h0,      1,6'd9,2'd3,22'h200123, 0,1,1,1,6'd9,4'b1000,{4{22'h200123}}, 0,4'h0,0));
        vecs.push_back(mk("wr9w1inv", 0,6'd0,21'h0,      1,6'd9,2'd1,22'h000123, 0,1,1,1,6'd9,4'b0010,{4{22'h000123}}, 0,4'h0,0));
        vecs.push_back(mk("lk9",      1,6'd9,21'h000123, 0,6'd0,2'd0,22'h0,      1,1,1,0,6'd9,4'b0000,88'h0,            0,4'h0,0));
        vecs.push_back(mk("idle2",    0,6'd0,21'h0,      0,6'd0,2'd0,22'h0,      1,1,0,0,6'd0,4'b0000,88'h0,            1,4'b1001,1));

        // Reset values while reset_n is held low.
        repeat (3) @(posedge clock);
        #1;
        check("rst.ready", {bus.lkp_ready, bus.wr_ready}, 2'b00);
        check("rst.resp",  {bus.resp_valid, bus.resp_hit, bus.resp_multi}, 6'h0);
        check("rst.stat",  {bus.busy, bus.init_done}, 2'b10);
        check("rst.sram",  {sram_en, sram_wmode, sram_addr, sram_wmask}, 12'h0);

        // Post-reset sweep, then RUN in cycle 64.
        reset_n = 1'b1;
        sweep_check("init", 0, 63, 1'b0);
        @(negedge clock);
        check("init.c64", {bus.busy, bus.init_done, bus.lkp_ready, bus.wr_ready, sram_en}, 5'b01110);
        @(posedge clock); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].lv, vecs[i].ls, vecs[i].lt, vecs[i].wv, vecs[i].ws, vecs[i].ww, vecs[i].we, 0);
            @(negedge clock);
            check({vecs[i].name, ".lkp_ready"}, bus.lkp_ready, vecs[i].e_lr);
            check({vecs[i].name, ".wr_ready"},  bus.wr_ready,  vecs[i].e_wr);
            check({vecs[i].name, ".sram"}, {sram_en, sram_wmode, sram_addr, sram_wmask},
                  {vecs[i].e_en, vecs[i].e_wm, vecs[i].e_addr, vecs[i].e_mask});
            check({vecs[i].name, ".wdata"}, sram_wdata, vecs[i].e_wdata);
            check({vecs[i].name, ".resp"}, {bus.resp_valid, bus.resp_hit, bus.resp_multi},
                  {vecs[i].e_rv, vecs[i].e_hit, vecs[i].e_multi});
            @(posedge clock); #1;
        end

        // Contention: writes win four times, then the starved lookup gets one slot.
        drive(1, 6'd5, 21'h0ABCDE, 1, 6'd10, 2'd0, 22'h0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            lg    = bus.lkp_valid && bus.lkp_ready;
            wg    = bus.wr_valid && bus.wr_ready;
            exp_l = (i == 4) || (i == 9);
            check($sformatf("starve.gnt[%0d]", i), {lg, wg}, {exp_l, !exp_l});
            if (i == 5) check("starve.resp5", {bus.resp_valid, bus.resp_hit}, {1'b1, 4'b0100});
            @(posedge clock); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("starve.resp10", {bus.resp_valid, bus.resp_hit, bus.resp_multi}, {1'b1, 4'b0100, 1'b0});
        @(posedge clock); #1;

        // Flush raised alongside a lookup grant; the response still arrives.
        drive(1, 6'd5, 21'h0ABCDE, 0, 0, 0, 0, 1);
        @(negedge clock);
        check("fl.grant", {bus.lkp_ready, bus.busy, sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, 1'b1, 1'b0, 6'd5});
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);  // flush during FLUSH must be dropped
        @(negedge clock);
        check("fl.resp",  {bus.resp_valid, bus.resp_hit, bus.resp_multi}, {1'b1, 4'b0100, 1'b0});
        check("fl.sweep0", {sram_en, sram_wmode, sram_addr, sram_wmask, bus.busy, bus.lkp_ready, bus.wr_ready},
              {1'b1, 1'b1, 6'd0, 4'hF, 1'b1, 1'b0, 1'b0});
        @(posedge clock); #1;
        bus.flush_req = 1'b0;
        sweep_check("flush", 1, 63, 1'b1);
        @(negedge clock);
        check("fl.run", {bus.busy, bus.lkp_ready, bus.wr_ready, sram_en}, 4'b0110);
        @(posedge clock); #1;
        drive(1, 6'd5, 21'h0ABCDE, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("fl.lk5", {bus.busy, sram_en, sram_wmode, sram_addr}, {1'b0, 1'b1, 1'b0, 6'd5});
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("fl.lk5resp", {bus.busy, bus.resp_valid, bus.resp_hit, bus.resp_multi}, {1'b0, 1'b1, 4'h0, 1'b0});
        @(posedge clock); #1;

        // Second flush, interrupted by reset at sweep address 30.
        bus.flush_req = 1'b1;
        @(negedge clock);
        check("fl2.req", bus.busy, 1'b0);
        @(posedge clock); #1;
        bus.flush_req = 1'b0;
        sweep_check("flush2", 0, 30, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("arst.sram",  {sram_en, sram_wmode, sram_addr, sram_wmask}, 12'h0);
        check("arst.stat",  {bus.busy, bus.init_done, bus.lkp_ready, bus.wr_ready, bus.resp_valid}, 5'b10000);
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        sweep_check("reinit", 0, 63, 1'b0);
        @(negedge clock);
        check("reinit.c64", {bus.busy, bus.init_done, bus.lkp_ready}, 3'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
